// File: rtl/skein_nonce_scheduler_pkg.sv
// Shared types and field widths for the skein512 nonce scheduler.
package skein_sched_pkg;

    localparam int MIDSTATE_W = 512;
    localparam int DATA_W     = 96;
    localparam int TARGET_W   = 64;
    localparam int NONCE_W    = 32;
    localparam int HASH_W     = 512;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic [NONCE_W-1:0]  nonce;
        logic [TARGET_W-1:0] hash_hi;
    } result_t;

endpackage

// File: rtl/skein_nonce_scheduler_if.sv
// Work, core and result signals of the nonce scheduler; slave = scheduler side.
interface skein_nonce_scheduler_if;
    import skein_sched_pkg::*;

    logic                  work_valid;
    logic                  work_ready;
    logic [MIDSTATE_W-1:0] work_midstate;
    logic [DATA_W-1:0]     work_data;
    logic [TARGET_W-1:0]   work_target;
    logic [NONCE_W-1:0]    work_nonce_start;
    logic [NONCE_W-1:0]    work_nonce_end;
    logic                  abort;
    logic [MIDSTATE_W-1:0] core_midstate;
    logic [DATA_W-1:0]     core_data;
    logic [NONCE_W-1:0]    core_nonce;
    logic [HASH_W-1:0]     core_hash;
    logic                  busy;
    logic                  done;
    logic                  res_valid;
    logic                  res_ready;
    logic [NONCE_W-1:0]    res_nonce;
    logic [TARGET_W-1:0]   res_hash_hi;
    logic                  res_overflow;

    modport master (
        output work_valid, work_midstate, work_data, work_target,
               work_nonce_start, work_nonce_end, abort, core_hash, res_ready,
        input  work_ready, core_midstate, core_data, core_nonce, busy, done,
               res_valid, res_nonce, res_hash_hi, res_overflow
    );

    modport slave (
        input  work_valid, work_midstate, work_data, work_target,
               work_nonce_start, work_nonce_end, abort, core_hash, res_ready,
        output work_ready, core_midstate, core_data, core_nonce, busy, done,
               res_valid, res_nonce, res_hash_hi, res_overflow
    );

endinterface

// File: rtl/skein_nonce_scheduler_fifo.sv
// Shifting result FIFO: entry 0 is always the registered head (first-word fall-through).
module skein_result_fifo
    import skein_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    i_push,
    input  result_t i_data,
    input  logic    i_pop,
    output result_t o_head,
    output logic    o_empty,
    output logic    o_drop
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    result_t         r_mem [DEPTH];
    logic [CNTW-1:0] r_count;
    logic [AW-1:0]   w_wr_idx;
    logic            w_full;
    logic            w_pop;
    logic            w_push_ok;

    assign o_empty   = (r_count == '0);
    assign w_full    = (r_count == CNTW'(DEPTH));
    assign w_pop     = i_pop && !o_empty;
    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign w_push_ok = i_push && (!w_full || w_pop);
    assign o_drop    = i_push && w_full && !w_pop;
    assign w_wr_idx  = w_pop ? AW'(r_count - CNTW'(1)) : AW'(r_count);
    assign o_head    = r_mem[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (w_pop) r_mem[i] <= r_mem[i+1];
            end
            if (w_push_ok) r_mem[w_wr_idx] <= i_data;
            r_count <= r_count + CNTW'(w_push_ok) - CNTW'(w_pop);
        end
    end

endmodule

// File: rtl/skein_nonce_scheduler.sv
// Nonce sequencer for a pipelined skein512 core; SKEIN_SCHED_STATS_EN adds hash/win counters.
// state    | meaning
// ST_IDLE  | waiting for a work unit, work_ready high
// ST_RUN   | issuing nonces every ISSUE_INTERVAL cycles
// ST_DRAIN | last nonce issued, waiting for in-flight hashes to retire
module skein_nonce_scheduler
    import skein_sched_pkg::*;
#(
    parameter int PIPE_LATENCY   = 110,
    parameter int ISSUE_INTERVAL = 2,
    parameter int FIFO_DEPTH     = 4
) (
    input logic clk,
    input logic rst,
    skein_nonce_scheduler_if.slave bus
`ifdef SKEIN_SCHED_STATS_EN
    ,
    output logic [47:0] hashes_done,
    output logic [31:0] wins_total
`endif
);
    localparam int CW = (ISSUE_INTERVAL > 1) ? $clog2(ISSUE_INTERVAL) : 1;
    localparam int FW = $clog2(PIPE_LATENCY + 2);

    sched_state_t          r_state, w_state_nxt;
    logic [CW-1:0]         r_cnt;
    logic [NONCE_W-1:0]    r_nonce, r_nonce_end;
    logic [TARGET_W-1:0]   r_target;
    logic [MIDSTATE_W-1:0] r_midstate;
    logic [DATA_W-1:0]     r_data;
    logic [PIPE_LATENCY-1:0] r_tag_v;
    logic [NONCE_W-1:0]    r_tag_n [PIPE_LATENCY];
    logic [FW-1:0]         r_inflight;
    logic                  r_overflow;
    logic                  w_accept, w_issue, w_abort, w_done;
    logic                  w_retire, w_win, w_drop, w_empty;
    logic [TARGET_W-1:0]   w_hash_hi;
    result_t               w_entry, w_head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_issue     = 1'b0;
        w_abort     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.work_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == '0) begin
                    w_issue = 1'b1;
                    if (r_nonce == r_nonce_end) w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (bus.abort) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_inflight == '0) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_hash_hi = bus.core_hash[HASH_W-1 -: TARGET_W];
    // A retire coinciding with abort belongs to cancelled work and is discarded.
    assign w_retire  = r_tag_v[PIPE_LATENCY-1] && !w_abort;
    assign w_win     = w_retire && (w_hash_hi <= r_target);
    assign w_entry   = '{nonce: r_tag_n[PIPE_LATENCY-1], hash_hi: w_hash_hi};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_nonce     <= '0;
            r_nonce_end <= '0;
            r_target    <= '0;
            r_midstate  <= '0;
            r_data      <= '0;
            r_tag_v     <= '0;
            r_inflight  <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt       <= '0;
                r_nonce     <= bus.work_nonce_start;
                r_nonce_end <= bus.work_nonce_end;
                r_target    <= bus.work_target;
                r_midstate  <= bus.work_midstate;
                r_data      <= bus.work_data;
            end else if (r_state == ST_RUN) begin
                r_cnt <= (r_cnt == CW'(ISSUE_INTERVAL - 1)) ? '0 : r_cnt + CW'(1);
                if (w_issue && (r_nonce != r_nonce_end)) r_nonce <= r_nonce + NONCE_W'(1);
            end
            r_tag_v    <= w_abort ? '0 : {r_tag_v[PIPE_LATENCY-2:0], w_issue};
            r_inflight <= w_abort ? '0 : r_inflight + FW'(w_issue) - FW'(w_retire);
            if (w_accept)    r_overflow <= 1'b0;
            else if (w_drop) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        r_tag_n[0] <= r_nonce;
        for (int i = 1; i < PIPE_LATENCY; i++) r_tag_n[i] <= r_tag_n[i-1];
    end

    skein_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_win),
        .i_data  (w_entry),
        .i_pop   (bus.res_ready),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_drop  (w_drop)
    );

    assign bus.work_ready    = (r_state == ST_IDLE);
    assign bus.busy          = (r_state != ST_IDLE);
    assign bus.done          = w_done;
    assign bus.core_midstate = r_midstate;
    assign bus.core_data     = r_data;
    assign bus.core_nonce    = r_nonce;
    assign bus.res_valid     = !w_empty;
    assign bus.res_nonce     = w_head.nonce;
    assign bus.res_hash_hi   = w_head.hash_hi;
    assign bus.res_overflow  = r_overflow;

`ifdef SKEIN_SCHED_STATS_EN
    logic [47:0] r_hashes;
    logic [31:0] r_wins;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hashes <= '0;
            r_wins   <= '0;
        end else begin
            if (w_retire) r_hashes <= r_hashes + 48'd1;
            if (w_win)    r_wins   <= r_wins + 32'd1;
        end
    end

    assign hashes_done = r_hashes;
    assign wins_total  = r_wins;
`endif

endmodule

// File: tb/tb_skein_nonce_scheduler.sv
// Directed bench for skein_nonce_scheduler with an 8-cycle core stub (hash_hi = nonce).
module tb_skein_nonce_scheduler;
    import skein_sched_pkg::*;

    localparam int L  = 8;
    localparam int II = 2;

    logic clk = 1'b0;
    logic rst;

    skein_nonce_scheduler_if bus();

`ifdef SKEIN_SCHED_STATS_EN
    logic [47:0] hashes_done;
    logic [31:0] wins_total;
`endif

    skein_nonce_scheduler #(
        .PIPE_LATENCY   (L),
        .ISSUE_INTERVAL (II),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef SKEIN_SCHED_STATS_EN
        ,
        .hashes_done (hashes_done),
        .wins_total  (wins_total)
`endif
    );

    always #5 clk = ~clk;

    // Core stub: hash appears L cycles after the nonce was on core_nonce
    logic [31:0] stub_q [L];
    always @(posedge clk) begin
        stub_q[0] <= bus.core_nonce;
        for (int i = 1; i < L; i++) stub_q[i] <= stub_q[i-1];
    end
    assign bus.core_hash = {32'h0, stub_q[L-1], {14{stub_q[L-1]}}};

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    logic [31:0] got_n [$];
    logic [63:0] got_h [$];
    int          got_cyc [$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst && bus.done) done_cnt++;
        if (!rst && bus.res_valid && bus.res_ready) begin
            got_n.push_back(bus.res_nonce);
            got_h.push_back(bus.res_hash_hi);
            got_cyc.push_back(cyc);
        end
    end

    typedef struct {
        logic [31:0] ns;
        logic [31:0] ne;
        logic [63:0] tgt;
        bit          ready;
        int          exp_n;
        logic [31:0] exp_first;
        bit          exp_ovf;
    } vec_t;

    vec_t vecs [6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_got();
        got_n.delete();
        got_h.delete();
        got_cyc.delete();
    endtask

    task automatic offer(input logic [31:0] ns, input logic [31:0] ne, input logic [63:0] tgt);
        bus.work_midstate    = {16{ns}};
        bus.work_data        = {3{ne}};
        bus.work_target      = tgt;
        bus.work_nonce_start = ns;
        bus.work_nonce_end   = ne;
        bus.work_valid       = 1'b1;
        step();
        bus.work_valid       = 1'b0;
    endtask

    task automatic run_vec(input int vi);
        vec_t        v;
        logic [31:0] n_iss;
        logic [31:0] en;
        int          k;
        int          d0;
        v     = vecs[vi];
        n_iss = v.ne - v.ns + 32'd1;
        clear_got();
        bus.res_ready = v.ready;
        chk("work_ready_idle", 64'(bus.work_ready), 64'd1);
        offer(v.ns, v.ne, v.tgt);
        chk("busy_run", 64'(bus.busy), 64'd1);
        chk("work_ready_run", 64'(bus.work_ready), 64'd0);
        chk("overflow_cleared_on_accept", 64'(bus.res_overflow), 64'd0);
        chk("core_nonce_start", 64'(bus.core_nonce), 64'(v.ns));
        chk("core_data", bus.core_data[63:0], {v.ne, v.ne});
        chk("core_midstate", bus.core_midstate[511:448], {v.ns, v.ns});
        d0 = done_cnt;
        k  = 0;
        while (bus.done !== 1'b1 && k < 600) begin
            step();
            k++;
        end
        chk("done_latency", 64'(k), 64'(2 * (n_iss - 32'd1) + L + 1));
        chk("busy_at_done", 64'(bus.busy), 64'd1);
        step();
        chk("done_single_pulse", 64'(bus.done), 64'd0);
        chk("busy_after_done", 64'(bus.busy), 64'd0);
        chk("work_ready_after_done", 64'(bus.work_ready), 64'd1);
        if (!v.ready) begin
            chk("overflow_at_done", 64'(bus.res_overflow), 64'(v.exp_ovf));
            bus.res_ready = 1'b1;
        end
        repeat (12) step();
        chk("done_count", 64'(done_cnt - d0), 64'd1);
        chk("result_count", 64'(got_n.size()), 64'(v.exp_n));
        for (int i = 0; i < got_n.size() && i < v.exp_n; i++) begin
            en = v.exp_first + 32'(i);
            chk("result_nonce", 64'(got_n[i]), 64'(en));
            chk("result_hash_hi", got_h[i], {32'h0, en});
            if (v.ready && i > 0)
                chk("result_spacing", 64'(got_cyc[i] - got_cyc[i-1]), 64'(II));
        end
        chk("overflow_sticky", 64'(bus.res_overflow), 64'(v.exp_ovf));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        for (int i = 0; i < L; i++) stub_q[i] = '0;
        rst                  = 1'b0;
        bus.work_valid       = 1'b0;
        bus.work_midstate    = '0;
        bus.work_data        = '0;
        bus.work_target      = '0;
        bus.work_nonce_start = '0;
        bus.work_nonce_end   = '0;
        bus.abort            = 1'b0;
        bus.res_ready        = 1'b0;

        //        start         end           target                 rdy n  first         ovf
        vecs[0] = '{32'h10,       32'h10,       64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 32'h10,       0};
        vecs[1] = '{32'hFFFFFFFE, 32'h1,        64'hFFFF_FFFF_FFFF_FFFF, 1, 4, 32'hFFFFFFFE, 0};
        vecs[2] = '{32'h0,        32'hF,        64'h5,                   1, 6, 32'h0,        0};
        vecs[3] = '{32'h0,        32'h9,        64'hFFFF_FFFF_FFFF_FFFF, 0, 4, 32'h0,        1};
        vecs[4] = '{32'h5,        32'h9,        64'h7,                   1, 3, 32'h5,        0};
        vecs[5] = '{32'h3,        32'h7,        64'h0,                   1, 0, 32'h3,        0};

        #1 rst = 1'b1;
        repeat (2) step();
        chk("reset_work_ready", 64'(bus.work_ready), 64'd1);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_res_valid", 64'(bus.res_valid), 64'd0);
        chk("reset_overflow", 64'(bus.res_overflow), 64'd0);
        chk("reset_core_nonce", 64'(bus.core_nonce), 64'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 6; i++) run_vec(i);

        // Abort after three issues
        clear_got();
        bus.res_ready = 1'b1;
        offer(32'h100, 32'h1FF, 64'hFFFF_FFFF_FFFF_FFFF);
        repeat (5) step();
        chk("abort_nonce_before", 64'(bus.core_nonce), 64'h103);
        chk("abort_busy_before", 64'(bus.busy), 64'd1);
        d0 = done_cnt;
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("abort_work_ready", 64'(bus.work_ready), 64'd1);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        repeat (30) step();
        chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
        chk("abort_no_results", 64'(got_n.size()), 64'd0);

        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("idle_abort_work_ready", 64'(bus.work_ready), 64'd1);
        chk("idle_abort_busy", 64'(bus.busy), 64'd0);

        // Async reset while draining with two results queued
        clear_got();
        bus.res_ready = 1'b0;
        offer(32'h0, 32'h2, 64'hFFFF_FFFF_FFFF_FFFF);
        repeat (11) step();
        chk("pre_reset_busy", 64'(bus.busy), 64'd1);
        chk("pre_reset_res_valid", 64'(bus.res_valid), 64'd1);
        chk("pre_reset_done", 64'(bus.done), 64'd0);
        rst = 1'b1;
        #1;
        chk("async_reset_res_valid", 64'(bus.res_valid), 64'd0);
        chk("async_reset_busy", 64'(bus.busy), 64'd0);
        chk("async_reset_work_ready", 64'(bus.work_ready), 64'd1);
        chk("async_reset_overflow", 64'(bus.res_overflow), 64'd0);
        repeat (2) step();
        rst = 1'b0;
        bus.res_ready = 1'b1;
        d0 = done_cnt;
        repeat (15) step();
        chk("post_reset_no_results", 64'(got_n.size()), 64'd0);
        chk("post_reset_no_done", 64'(done_cnt - d0), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/skein_nonce_scheduler.md
Name: skein_nonce_scheduler

Overview:
- Work sequencer in front of the fully pipelined skein512 core.
- Accepts one work unit: midstate, 96-bit data tail, 64-bit target and inclusive nonce range.
- Issues nonces to the core at the core's accept rate and tags every in-flight nonce through a delay line matched to core latency.
- Compares returned hashes against the target and queues winning nonces in a small result FIFO with a valid/ready handshake.

Parameters:
- PIPE_LATENCY, 110: cycles from a nonce being driven on core_nonce to its hash appearing on core_hash.
- ISSUE_INTERVAL, 2: cycles between consecutive nonce issues. Matches the core's two-pass phase alternation.
- FIFO_DEPTH, 4: result FIFO entries. Power of two, ≥ 2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- work_valid  in  1  work offer
- work_ready  out  1  high only in IDLE
- work_midstate  in  512  midstate
- work_data  in  96  data tail
- work_target  in  64  hash is a winner iff core_hash[511:448] <= target (unsigned)
- work_nonce_start  in  32  first nonce
- work_nonce_end  in  32  last nonce, inclusive
- abort  in  1  cancel current work
- core_midstate  out  512  registered copy of work_midstate
- core_data  out  96  registered copy of work_data
- core_nonce  out  32  nonce to core
- core_hash  in  512  core output
- busy  out  1  high in RUN or DRAIN
- done  out  1  one-cycle pulse on normal completion
- res_valid  out  1  FIFO non-empty
- res_ready  in  1  consumer accept
- res_nonce  out  32  winning nonce
- res_hash_hi  out  64  core_hash[511:448] of the winner
- res_overflow  out  1  sticky; set when a winner is dropped because the FIFO is full

Behaviour:
- Reset values:
  - state IDLE
  - all outputs 0, except work_ready = 1
  - tag line all invalid; FIFO empty
  - res_overflow = 0
- States: IDLE, RUN, DRAIN.
- IDLE:
  - work_valid && work_ready: latch all work fields.
  - core_nonce <= work_nonce_start; issue counter <= 0.
  - Next state RUN; first issue occurs on the first RUN cycle.
- RUN:
  - Issue counter counts 0..ISSUE_INTERVAL-1; the issue event fires when it is 0.
  - On an issue event, push {1, core_nonce} into the tag line; otherwise push {0, x}.
  - The cycle after an issue, core_nonce increments, or holds if the issued nonce equals nonce_end.
  - After the nonce_end issue, next state DRAIN.
  - Increment is modulo 2^32. If nonce_end < nonce_start, the range wraps through 0xFFFFFFFF→0.
  - nonce_start == nonce_end issues exactly one nonce.
- Tag line:
  - PIPE_LATENCY-deep shift register of {valid, nonce}, advancing every cycle.
  - When the tail entry is valid, compare core_hash[511:448] to the target on the same cycle.
  - A winner pushes {nonce, hash_hi} into the FIFO.
- In-flight counter:
  - +1 on issue, −1 on tail-valid.
  - Same-cycle issue and retire leaves it unchanged.
- DRAIN:
  - Wait for in-flight == 0.
  - Then pulse done for one cycle and return to IDLE.
- FIFO:
  - Pop on res_valid && res_ready.
  - Simultaneous push and pop when full is allowed: no drop, count unchanged.
  - Push when full with no pop: drop the entry and set res_overflow. It clears only on rst or on a new work accept.
  - res_* are the head entry, registered, first-word fall-through.
- abort, in RUN or DRAIN:
  - Next cycle: state IDLE, all tag valids cleared, in-flight 0.
  - done is not pulsed.
  - FIFO contents are preserved.
  - abort in IDLE is ignored.
  - abort has priority over a same-cycle DRAIN completion.
- work_valid outside IDLE is ignored (work_ready = 0).
- rst asserted mid-operation returns everything to reset values asynchronously.
- core_midstate and core_data are stable from work accept until the next accept.

Optional Feature:
- Macro SKEIN_SCHED_STATS_EN.
- Defined: adds output hashes_done [47:0], incremented on every tail-valid retire and cleared on rst only.
- Defined: adds output wins_total [31:0], counting FIFO pushes including dropped ones.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Package skein_sched_pkg holds:
  - state enum typedef (IDLE/RUN/DRAIN)
  - result entry struct {nonce[31:0], hash_hi[63:0]}
  - localparams for the 512/96/64/32 field widths
- One sub-module: skein_result_fifo (parameterised depth, push/pop/full/empty, drop-on-full flag).

Test Plan:
- Single nonce:
  - Stimulus: start = end = 0x00000010, target = 0xFFFF_FFFF_FFFF_FFFF, core stub with PIPE_LATENCY = 8.
  - Required response: one FIFO entry, res_nonce = 0x10; done pulses exactly once; busy spans RUN + DRAIN.
- Wrap range:
  - Stimulus: start = 0xFFFFFFFE, end = 0x00000001, target all-ones.
  - Required response: results 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1 in order; issue spacing is exactly 2 cycles.
- Target compare:
  - Stimulus: stub returns hash_hi = nonce; target = 0x5; range 0..15.
  - Required response: exactly nonces 0..5 reported.
- FIFO overflow:
  - Stimulus: res_ready = 0, target all-ones, range 0..9.
  - Required response: 4 entries (nonces 0..3) retained; res_overflow = 1; draining returns 0..3.
- Abort:
  - Stimulus: assert abort mid-RUN after 3 issues.
  - Required response: IDLE next cycle; no done; later stub hashes not reported; work_ready = 1.
- Async reset:
  - Stimulus: pulse rst while in DRAIN with 2 FIFO entries.
  - Required response: immediately res_valid = 0, busy = 0, work_ready = 1, res_overflow = 0.
